// File: rtl/skeleton.sv
// skeleton: single-cycle ECE550-style CPU (PC, decode, ALU, regfile, imem ROM, dmem RAM) with all buses exported.
// Define SKELETON_EXCEPTION_EN to divert add/addi/sub signed overflow into $r30 = 1/2/3.
module skeleton #(
    parameter string IMEM_INIT = "imem.mif.hex"
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_clock,
    output logic        dmem_clock,
    output logic        processor_clock,
    output logic        regfile_clock,
    output logic [11:0] address_imem,
    output logic [31:0] q_imem,
    output logic [11:0] address_dmem,
    output logic [31:0] data,
    output logic        wren,
    output logic [31:0] q_dmem,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_writeReg,
    output logic [31:0] data_readRegA,
    output logic [31:0] data_readRegB,
    output logic [31:0] register0,  output logic [31:0] register1,  output logic [31:0] register2,
    output logic [31:0] register3,  output logic [31:0] register4,  output logic [31:0] register5,
    output logic [31:0] register6,  output logic [31:0] register7,  output logic [31:0] register8,
    output logic [31:0] register9,  output logic [31:0] register10, output logic [31:0] register11,
    output logic [31:0] register12, output logic [31:0] register13, output logic [31:0] register14,
    output logic [31:0] register15, output logic [31:0] register16, output logic [31:0] register17,
    output logic [31:0] register18, output logic [31:0] register19, output logic [31:0] register20,
    output logic [31:0] register21, output logic [31:0] register22, output logic [31:0] register23,
    output logic [31:0] register24, output logic [31:0] register25, output logic [31:0] register26,
    output logic [31:0] register27, output logic [31:0] register28, output logic [31:0] register29,
    output logic [31:0] register30, output logic [31:0] register31,
    output logic [31:0] alu1out,
    output logic [31:0] mux1out,
    output logic [31:0] signout,
    output logic [31:0] rwdout,
    output logic        dmwe2
);
    logic [31:0] imem [0:4095];
    logic [31:0] dmem_q [0:4095];
    logic [31:0] regs_q [0:31];
    logic [31:0] pc_q, pc_d, pc1, sum, diff, sra_r;
    logic [4:0]  op, rd, rs, rt, shamt, aluop, alu_sel;
    logic [26:0] target;
    logic        r_op, j_op, bne_op, jal_op, jr_op, addi_op, blt_op, lw_op, setx_op, bex_op;
    logic        r_valid, taken;
    logic [1:0]  trap_code;

    assign imem_clock      = clock;
    assign dmem_clock      = clock;
    assign processor_clock = clock;
    assign regfile_clock   = clock;

    assign address_imem = pc_q[11:0];
    assign q_imem       = imem[address_imem];
    assign {op, rd, rs, rt, shamt, aluop} = q_imem[31:2];
    assign target       = q_imem[26:0];
    assign signout      = {{15{q_imem[16]}}, q_imem[16:0]};

    assign r_op    = op == 5'd0;
    assign j_op    = op == 5'd1;
    assign bne_op  = op == 5'd2;
    assign jal_op  = op == 5'd3;
    assign jr_op   = op == 5'd4;
    assign addi_op = op == 5'd5;
    assign blt_op  = op == 5'd6;
    assign dmwe2   = op == 5'd7;
    assign lw_op   = op == 5'd8;
    assign setx_op = op == 5'd21;
    assign bex_op  = op == 5'd22;
    assign r_valid = r_op && aluop <= 5'd5;

    // Branch/store/jr compare or store $rd, so it rides on port B
    assign ctrl_readRegA = rs;
    assign ctrl_readRegB = r_op ? rt : bex_op ? 5'd30 : (dmwe2 | bne_op | blt_op | jr_op) ? rd : rt;
    assign data_readRegA = regs_q[ctrl_readRegA];
    assign data_readRegB = regs_q[ctrl_readRegB];

    assign mux1out = (addi_op | dmwe2 | lw_op) ? signout : data_readRegB;
    assign sum     = data_readRegA + mux1out;
    assign diff    = data_readRegA - mux1out;
    assign sra_r   = $signed(data_readRegA) >>> shamt;
    assign alu_sel = r_op ? aluop : 5'd0;

    always_comb begin
        alu1out = alu_sel == 5'd0 ? sum :
                  alu_sel == 5'd1 ? diff :
                  alu_sel == 5'd2 ? data_readRegA & mux1out :
                  alu_sel == 5'd3 ? data_readRegA | mux1out :
                  alu_sel == 5'd4 ? data_readRegA << shamt :
                  alu_sel == 5'd5 ? sra_r : '0;
    end

`ifdef SKELETON_EXCEPTION_EN
    logic add_ovf, sub_ovf;
    assign add_ovf   = (data_readRegA[31] == mux1out[31]) && (sum[31] != data_readRegA[31]);
    assign sub_ovf   = (data_readRegA[31] != mux1out[31]) && (diff[31] != data_readRegA[31]);
    assign trap_code = (r_op && aluop == 5'd0 && add_ovf) ? 2'd1 :
                       (addi_op && add_ovf)               ? 2'd2 :
                       (r_op && aluop == 5'd1 && sub_ovf) ? 2'd3 : 2'd0;
`else
    assign trap_code = 2'd0;
`endif

    assign ctrl_writeEnable = (r_valid | addi_op | lw_op | jal_op | setx_op) & ~reset;
    assign ctrl_writeReg    = (trap_code != 2'd0) ? 5'd30 : jal_op ? 5'd31 : setx_op ? 5'd30 : rd;
    assign data_writeReg    = (trap_code != 2'd0) ? {30'd0, trap_code} :
                              lw_op ? q_dmem : jal_op ? pc1 : setx_op ? {5'd0, target} : alu1out;
    assign rwdout           = data_writeReg;

    assign address_dmem = alu1out[11:0];
    assign data         = data_readRegB;
    assign wren         = dmwe2 & ~reset;
    assign q_dmem       = dmem_q[address_dmem];

    assign pc1   = pc_q + 32'd1;
    assign taken = (bne_op && data_readRegB != data_readRegA) ||
                   (blt_op && $signed(data_readRegB) < $signed(data_readRegA));

    always_comb begin
        pc_d = (j_op | jal_op) ? {5'd0, target} :
               jr_op ? data_readRegB :
               taken ? pc1 + signout :
               (bex_op && data_readRegB != 32'd0) ? {5'd0, target} : pc1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            if (ctrl_writeEnable && ctrl_writeReg != 5'd0) regs_q[ctrl_writeReg] <= data_writeReg;
        end
        if (wren) dmem_q[address_dmem] <= data;
    end

    assign register0  = '0;
    assign register1  = regs_q[1];  assign register2  = regs_q[2];  assign register3  = regs_q[3];
    assign register4  = regs_q[4];  assign register5  = regs_q[5];  assign register6  = regs_q[6];
    assign register7  = regs_q[7];  assign register8  = regs_q[8];  assign register9  = regs_q[9];
    assign register10 = regs_q[10]; assign register11 = regs_q[11]; assign register12 = regs_q[12];
    assign register13 = regs_q[13]; assign register14 = regs_q[14]; assign register15 = regs_q[15];
    assign register16 = regs_q[16]; assign register17 = regs_q[17]; assign register18 = regs_q[18];
    assign register19 = regs_q[19]; assign register20 = regs_q[20]; assign register21 = regs_q[21];
    assign register22 = regs_q[22]; assign register23 = regs_q[23]; assign register24 = regs_q[24];
    assign register25 = regs_q[25]; assign register26 = regs_q[26]; assign register27 = regs_q[27];
    assign register28 = regs_q[28]; assign register29 = regs_q[29]; assign register30 = regs_q[30];
    assign register31 = regs_q[31];
endmodule

// File: tb/tb_skeleton.sv
// tb_skeleton: directed programs poked into the instruction ROM, checked against hand-computed results.
module tb_skeleton;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_clock, dmem_clock, processor_clock, regfile_clock;
    logic [11:0] address_imem, address_dmem;
    logic [31:0] q_imem, data, q_dmem, data_writeReg, data_readRegA, data_readRegB;
    logic        wren, ctrl_writeEnable, dmwe2;
    logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
    logic [31:0] alu1out, mux1out, signout, rwdout;
    logic [31:0] r [0:31];
    int total = 0;
    int bad = 0;

    skeleton #(.IMEM_INIT("")) dut (
        .clock(clock), .reset(reset),
        .imem_clock(imem_clock), .dmem_clock(dmem_clock),
        .processor_clock(processor_clock), .regfile_clock(regfile_clock),
        .address_imem(address_imem), .q_imem(q_imem),
        .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_writeReg(data_writeReg), .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
        .register0(r[0]),   .register1(r[1]),   .register2(r[2]),   .register3(r[3]),
        .register4(r[4]),   .register5(r[5]),   .register6(r[6]),   .register7(r[7]),
        .register8(r[8]),   .register9(r[9]),   .register10(r[10]), .register11(r[11]),
        .register12(r[12]), .register13(r[13]), .register14(r[14]), .register15(r[15]),
        .register16(r[16]), .register17(r[17]), .register18(r[18]), .register19(r[19]),
        .register20(r[20]), .register21(r[21]), .register22(r[22]), .register23(r[23]),
        .register24(r[24]), .register25(r[25]), .register26(r[26]), .register27(r[27]),
        .register28(r[28]), .register29(r[29]), .register30(r[30]), .register31(r[31]),
        .alu1out(alu1out), .mux1out(mux1out), .signout(signout), .rwdout(rwdout), .dmwe2(dmwe2)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ri(input int rd, input int rs, input int rt, input int sh, input int fn);
        return {5'd0, rd[4:0], rs[4:0], rt[4:0], sh[4:0], fn[4:0], 2'b00};
    endfunction
    function automatic logic [31:0] ii(input int op, input int rd, input int rs, input int imm);
        return {op[4:0], rd[4:0], rs[4:0], imm[16:0]};
    endfunction
    function automatic logic [31:0] jj(input int op, input int t);
        return {op[4:0], t[26:0]};
    endfunction

    task clear_rom;
        for (int i = 0; i < 4096; i++) dut.imem[i] = 32'h0;
    endtask

    task start;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task run(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    task test_reset;
        clear_rom;
        dut.imem[0] = ii(5, 1, 0, 7);
        dut.imem[1] = ii(7, 1, 0, 3);
        dut.imem[2] = ii(5, 2, 0, 1);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++; if (address_imem !== 12'd0) begin bad++; $display("FAIL reset_pc got=%0d want=0", address_imem); end
        total++; if (ctrl_writeEnable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", ctrl_writeEnable); end
        reset = 1'b0;
        run(1);
        total++; if ({wren, address_dmem, data} !== {1'b1, 12'd3, 32'd7}) begin bad++; $display("FAIL sw_port got=%b/%0d/%0d want=1/3/7", wren, address_dmem, data); end
        reset = 1'b1;
        #1;
        total++; if ({dmwe2, wren} !== 2'b10) begin bad++; $display("FAIL reset_wren got dmwe2/wren=%b%b want=10", dmwe2, wren); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int i = 1; i < 32; i++) begin
            total++; if (r[i] !== 32'd0) begin bad++; $display("FAIL reset_r%0d got=%h want=0", i, r[i]); end
        end
        total++; if (address_imem !== 12'd0) begin bad++; $display("FAIL reset_pc2 got=%0d want=0", address_imem); end
    endtask

    task test_arith;
        clear_rom;
        dut.imem[0] = ii(5, 1, 0, 5);
        dut.imem[1] = ii(5, 2, 0, -3);
        dut.imem[2] = ri(3, 1, 2, 0, 0);
        dut.imem[3] = ri(4, 1, 0, 2, 4);
        dut.imem[4] = ri(5, 1, 2, 0, 1);
        dut.imem[5] = ri(6, 1, 2, 0, 2);
        dut.imem[6] = ri(7, 1, 2, 0, 3);
        dut.imem[7] = ri(8, 2, 0, 1, 5);
        dut.imem[8] = ri(9, 1, 1, 0, 6);
        dut.imem[9] = ii(5, 0, 0, 9);
        start;
        run(1);
        total++; if (signout !== 32'hFFFFFFFD) begin bad++; $display("FAIL signout got=%h want=fffffffd", signout); end
        total++; if (mux1out !== 32'hFFFFFFFD) begin bad++; $display("FAIL mux1out got=%h want=fffffffd", mux1out); end
        total++; if ({ctrl_writeEnable, ctrl_writeReg} !== {1'b1, 5'd2}) begin bad++; $display("FAIL addi_wport got=%b/%0d want=1/2", ctrl_writeEnable, ctrl_writeReg); end
        run(9);
        total++; if (r[1] !== 32'd5) begin bad++; $display("FAIL addi_r1 got=%h want=5", r[1]); end
        total++; if (r[3] !== 32'd2) begin bad++; $display("FAIL add_r3 got=%h want=2", r[3]); end
        total++; if (r[4] !== 32'd20) begin bad++; $display("FAIL sll_r4 got=%h want=14", r[4]); end
        total++; if (r[5] !== 32'd8) begin bad++; $display("FAIL sub_r5 got=%h want=8", r[5]); end
        total++; if (r[6] !== 32'd5) begin bad++; $display("FAIL and_r6 got=%h want=5", r[6]); end
        total++; if (r[7] !== 32'hFFFFFFFD) begin bad++; $display("FAIL or_r7 got=%h want=fffffffd", r[7]); end
        total++; if (r[8] !== 32'hFFFFFFFE) begin bad++; $display("FAIL sra_r8 got=%h want=fffffffe", r[8]); end
        total++; if (r[9] !== 32'd0) begin bad++; $display("FAIL bad_aluop_r9 got=%h want=0", r[9]); end
        total++; if (r[0] !== 32'd0) begin bad++; $display("FAIL r0 got=%h want=0", r[0]); end
    endtask

    task test_mem;
        clear_rom;
        dut.imem[0] = ii(5, 1, 0, 100);
        dut.imem[1] = ii(7, 1, 0, 4);
        dut.imem[2] = ii(8, 5, 0, 4);
        dut.imem[3] = ii(5, 6, 0, 2);
        dut.imem[4] = ii(8, 7, 6, 2);
        start;
        run(1);
        total++; if ({wren, address_dmem, data} !== {1'b1, 12'd4, 32'd100}) begin bad++; $display("FAIL sw4 got=%b/%0d/%0d want=1/4/100", wren, address_dmem, data); end
        run(2);
        total++; if (r[5] !== 32'd100) begin bad++; $display("FAIL lw_r5 got=%0d want=100", r[5]); end
        run(2);
        total++; if (r[7] !== 32'd100) begin bad++; $display("FAIL lw_base_r7 got=%0d want=100", r[7]); end
        clear_rom;
        dut.imem[0] = ii(8, 8, 0, 4);
        start;
        run(1);
        total++; if (r[8] !== 32'd100) begin bad++; $display("FAIL dmem_retain got=%0d want=100", r[8]); end
    endtask

    task test_overflow;
        logic [31:0] e30a, e3, e30b, e4, e5;
`ifdef SKELETON_EXCEPTION_EN
        e30a = 32'd1; e3 = 32'd0; e30b = 32'd3; e4 = 32'd0; e5 = 32'd0;
`else
        e30a = 32'd0; e3 = 32'hFFFFFFFE; e30b = 32'd0; e4 = 32'h80000000; e5 = 32'h80000000;
`endif
        clear_rom;
        dut.imem[0] = ii(5, 1, 0, 1);
        dut.imem[1] = ri(1, 1, 0, 30, 4);
        dut.imem[2] = ii(5, 2, 1, -1);
        dut.imem[3] = ri(1, 1, 2, 0, 0);
        dut.imem[4] = ii(5, 7, 0, -1);
        dut.imem[5] = ri(3, 1, 1, 0, 0);
        dut.imem[6] = ii(5, 4, 1, 1);
        dut.imem[7] = ri(5, 1, 7, 0, 1);
        dut.imem[8] = ri(6, 1, 7, 0, 0);
        start;
        run(6);
        total++; if (r[1] !== 32'h7FFFFFFF) begin bad++; $display("FAIL ovf_r1 got=%h want=7fffffff", r[1]); end
        total++; if (r[3] !== e3) begin bad++; $display("FAIL ovf_add_r3 got=%h want=%h", r[3], e3); end
        total++; if (r[30] !== e30a) begin bad++; $display("FAIL ovf_add_r30 got=%h want=%h", r[30], e30a); end
        run(3);
        total++; if (r[4] !== e4) begin bad++; $display("FAIL ovf_addi_r4 got=%h want=%h", r[4], e4); end
        total++; if (r[5] !== e5) begin bad++; $display("FAIL ovf_sub_r5 got=%h want=%h", r[5], e5); end
        total++; if (r[30] !== e30b) begin bad++; $display("FAIL ovf_sub_r30 got=%h want=%h", r[30], e30b); end
        total++; if (r[6] !== 32'h7FFFFFFE) begin bad++; $display("FAIL noovf_r6 got=%h want=7ffffffe", r[6]); end
    endtask

    task test_branch;
        clear_rom;
        dut.imem[0]  = ii(5, 1, 0, 1);
        dut.imem[1]  = ii(5, 2, 0, 2);
        dut.imem[2]  = ii(2, 1, 2, 2);
        dut.imem[3]  = ii(5, 10, 0, 1);
        dut.imem[4]  = ii(5, 10, 0, 2);
        dut.imem[5]  = ii(6, 1, 2, 1);
        dut.imem[6]  = ii(5, 11, 0, 1);
        dut.imem[7]  = ii(2, 1, 1, 5);
        dut.imem[8]  = ii(6, 2, 1, 5);
        dut.imem[9]  = jj(3, 12);
        dut.imem[10] = ii(5, 12, 0, 3);
        dut.imem[11] = jj(1, 14);
        dut.imem[12] = ii(5, 13, 0, 4);
        dut.imem[13] = ii(4, 31, 0, 0);
        dut.imem[14] = ii(5, 14, 0, 5);
        dut.imem[15] = ii(5, 3, 0, -1);
        dut.imem[16] = ii(6, 3, 1, 1);
        dut.imem[17] = ii(5, 15, 0, 1);
        start;
        run(3);
        total++; if (address_imem !== 12'd5) begin bad++; $display("FAIL bne_taken pc=%0d want=5", address_imem); end
        run(1);
        total++; if (address_imem !== 12'd7) begin bad++; $display("FAIL blt_taken pc=%0d want=7", address_imem); end
        run(3);
        total++; if (address_imem !== 12'd12) begin bad++; $display("FAIL jal_pc pc=%0d want=12", address_imem); end
        total++; if (r[31] !== 32'd10) begin bad++; $display("FAIL jal_r31 got=%0d want=10", r[31]); end
        run(5);
        total++; if (address_imem !== 12'd15) begin bad++; $display("FAIL jr_path pc=%0d want=15", address_imem); end
        total++; if ({r[10], r[11]} !== 64'd0) begin bad++; $display("FAIL skipped_regs got=%h/%h want=0/0", r[10], r[11]); end
        total++; if ({r[12], r[13], r[14]} !== {32'd3, 32'd4, 32'd5}) begin bad++; $display("FAIL taken_regs got=%0d/%0d/%0d want=3/4/5", r[12], r[13], r[14]); end
        run(2);
        total++; if (address_imem !== 12'd18) begin bad++; $display("FAIL blt_signed pc=%0d want=18", address_imem); end
    endtask

    task test_setx_bex;
        clear_rom;
        dut.imem[0]    = jj(22, 20);
        dut.imem[1]    = jj(21, 7);
        dut.imem[2]    = jj(22, 20);
        dut.imem[3]    = ii(5, 1, 0, 1);
        dut.imem[20]   = ii(5, 2, 0, 9);
        dut.imem[21]   = jj(1, 4095);
        dut.imem[4095] = ii(5, 3, 0, 1);
        start;
        run(1);
        total++; if (address_imem !== 12'd1) begin bad++; $display("FAIL bex_fallthru pc=%0d want=1", address_imem); end
        run(2);
        total++; if (r[30] !== 32'd7) begin bad++; $display("FAIL setx_r30 got=%0d want=7", r[30]); end
        total++; if (address_imem !== 12'd20) begin bad++; $display("FAIL bex_taken pc=%0d want=20", address_imem); end
        run(1);
        total++; if ({r[1], r[2]} !== {32'd0, 32'd9}) begin bad++; $display("FAIL bex_target got=%0d/%0d want=0/9", r[1], r[2]); end
        run(2);
        total++; if ({address_imem, r[3]} !== {12'd0, 32'd1}) begin bad++; $display("FAIL pc_wrap got=%0d/%0d want=0/1", address_imem, r[3]); end
    endtask

    initial begin
        test_reset;
        test_arith;
        test_mem;
        test_overflow;
        test_branch;
        test_setx_bex;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
